// File: rtl/ifdef_serial_tx.sv
// ifdef_serial_tx: valid/ready word in, idle-high serial frame out (start, data LSB first,
// parity when DEFINE_A is defined, stop).
module ifdef_serial_tx #(
   parameter int DataWidth  = 8,
   parameter int ClksPerBit = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [DataWidth-1:0] i_data,
`ifdef DEFINE_A
   input  logic                 i_parity_odd,
`endif
   output logic                 o_serial,
   output logic                 o_busy,
   output logic                 o_done
);
   localparam int CW = $clog2(ClksPerBit) + 1;
   localparam int BW = $clog2(DataWidth) + 1;
   localparam logic [CW-1:0] CLK_LAST = CW'(ClksPerBit - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DataWidth - 1);
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef DEFINE_A
      PARITY,
`endif
      STOP
   } state_t;
   state_t               state_q, state_d;
   logic [CW-1:0]        clk_cnt_q;
   logic [BW-1:0]        bit_cnt_q;
   logic [DataWidth-1:0] shreg_q;
`ifdef DEFINE_A
   logic                 par_q;
`endif
   logic                 xfer, bit_end;
   assign xfer    = i_valid && o_ready;
   assign bit_end = clk_cnt_q == CLK_LAST;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = xfer ? START : IDLE;
         START:   state_d = bit_end ? DATA : START;
`ifdef DEFINE_A
         DATA:    state_d = (bit_end && bit_cnt_q == BIT_LAST) ? PARITY : DATA;
         PARITY:  state_d = bit_end ? STOP : PARITY;
`else
         DATA:    state_d = (bit_end && bit_cnt_q == BIT_LAST) ? STOP : DATA;
`endif
         STOP:    state_d = bit_end ? IDLE : STOP;
         default: state_d = IDLE;
      endcase
   end
   // Counters idle at zero so every state starts a fresh bit period.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
      end else begin
         clk_cnt_q <= (state_q == IDLE || bit_end) ? '0 : clk_cnt_q + 1'b1;
         bit_cnt_q <= (state_q != DATA) ? '0 :
                      !bit_end ? bit_cnt_q :
                      (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
         shreg_q   <= xfer ? i_data :
                      (state_q == DATA && bit_end) ? shreg_q >> 1 : shreg_q;
      end
   end
`ifdef DEFINE_A
   // Parity is resolved at capture; the shift register no longer holds the word later.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  par_q <= 1'b0;
      else if (xfer) par_q <= (^i_data) ^ i_parity_odd;
   end
`endif
   always_comb begin
      o_ready  = state_q == IDLE;
      o_busy   = state_q != IDLE;
      o_done   = state_q == STOP && bit_end;
      o_serial = 1'b1;
      case (state_q)
         START:   o_serial = 1'b0;
         DATA:    o_serial = shreg_q[0];
`ifdef DEFINE_A
         PARITY:  o_serial = par_q;
`endif
         default: o_serial = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_ifdef_serial_tx.sv
// tb_ifdef_serial_tx: random and directed frames on an 8x4 and a 1x1 instance, checked
// cycle by cycle against a queue of expected line/done values built per accepted word.
module tb_ifdef_serial_tx;
   localparam int DW0 = 8, CPB0 = 4, DW1 = 1, CPB1 = 1;
`ifdef DEFINE_A
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   typedef struct packed {logic s; logic d;} ent_t;
   logic clk = 0, rst_n = 0;
   logic v0 = 0, v1 = 0, odd0 = 0, odd1 = 0;
   logic [7:0] d0 = '0;
   logic [0:0] d1 = '0;
   logic rdy0, ser0, busy0, done0, rdy1, ser1, busy1, done1;
   int total = 0, bad = 0;
   ent_t q0[$], q1[$];
   always #5 clk = ~clk;
   ifdef_serial_tx #(.DataWidth(DW0), .ClksPerBit(CPB0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .o_ready(rdy0), .i_data(d0),
`ifdef DEFINE_A
      .i_parity_odd(odd0),
`endif
      .o_serial(ser0), .o_busy(busy0), .o_done(done0));
   ifdef_serial_tx #(.DataWidth(DW1), .ClksPerBit(CPB1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(rdy1), .i_data(d1),
`ifdef DEFINE_A
      .i_parity_odd(odd1),
`endif
      .o_serial(ser1), .o_busy(busy1), .o_done(done1));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   // Line bits in transmit order, bit 0 first.
   function automatic logic [15:0] frame_bits(input int dw, input logic [7:0] data, input logic odd);
      logic [15:0] fb = '0;
      int ones = 0;
      for (int i = 0; i < dw; i++) begin
         fb[1+i] = data[i];
         ones += int'(data[i]);
      end
      if (P == 1) fb[1+dw] = logic'(ones % 2) ^ odd;
      fb[1+dw+P] = 1'b1;
      return fb;
   endfunction
   task automatic cycle(input logic nv0, input logic [7:0] nd0, input logic no0,
                        input logic nv1, input logic nd1, input logic no1);
      logic idle0, idle1;
      logic [15:0] fb;
      ent_t e;
      @(negedge clk);
      idle0 = q0.size() == 0;
      idle1 = q1.size() == 0;
      if (idle0) begin
         chk("rdy0", rdy0, 1); chk("ser0", ser0, 1); chk("busy0", busy0, 0); chk("done0", done0, 0);
      end else begin
         e = q0.pop_front();
         chk("rdy0", rdy0, 0); chk("ser0", ser0, e.s); chk("busy0", busy0, 1); chk("done0", done0, e.d);
      end
      if (idle1) begin
         chk("rdy1", rdy1, 1); chk("ser1", ser1, 1); chk("busy1", busy1, 0); chk("done1", done1, 0);
      end else begin
         e = q1.pop_front();
         chk("rdy1", rdy1, 0); chk("ser1", ser1, e.s); chk("busy1", busy1, 1); chk("done1", done1, e.d);
      end
      v0 = nv0; d0 = nd0; odd0 = no0;
      v1 = nv1; d1 = nd1; odd1 = no1;
      if (nv0 && idle0 && rst_n) begin
         fb = frame_bits(DW0, nd0, no0);
         for (int i = 0; i < DW0 + 2 + P; i++)
            for (int c = 0; c < CPB0; c++)
               q0.push_back('{fb[i], (i == DW0 + 1 + P && c == CPB0 - 1)});
      end
      if (nv1 && idle1 && rst_n) begin
         fb = frame_bits(DW1, {7'b0, nd1}, no1);
         for (int i = 0; i < DW1 + 2 + P; i++)
            for (int c = 0; c < CPB1; c++)
               q1.push_back('{fb[i], (i == DW1 + 1 + P && c == CPB1 - 1)});
      end
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 0, 0);
   endtask
   initial begin
      idle(3);
      #2 rst_n = 1;
      cycle(1, 8'hA5, 0, 1, 1, 0);
      idle(50);
      cycle(1, 8'h07, 0, 1, 0, 1);
      idle(50);
      cycle(1, 8'h07, 1, 1, 1, 1);
      idle(50);
      for (int i = 0; i < 150; i++)
         cycle(1, 8'($urandom), 1'($urandom), 1, 1'($urandom), 1'($urandom));
      idle(50);
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 2) == 0, 8'($urandom), 1'($urandom),
               $urandom_range(0, 1) == 0, 1'($urandom), 1'($urandom));
      idle(50);
      cycle(1, 8'h3C, 0, 0, 0, 0);
      idle(1 + CPB0 + 3 * CPB0 + 1);
      #2 rst_n = 0;
      #1 chk("rst_ser0", ser0, 1);
      chk("rst_done0", done0, 0);
      chk("rst_rdy0", rdy0, 1);
      q0.delete();
      q1.delete();
      idle(3);
      #2 rst_n = 1;
      cycle(1, 8'hFF, 0, 1, 1, 0);
      idle(60);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
